// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial word receiver slice.
//   DEFAULT_WIDTH : word width matching the 4-bit parallel-load serialiser
//   rx_state_t    : collector FSM encoding (IDLE = no bits held, COLLECT = partial word)
//   QUEUE_DEPTH   : number of completed words the output queue can hold
package serial_rx_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned QUEUE_DEPTH   = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/serial_word_rx_fifo.sv
// word_fifo2: two-entry FIFO holding recovered words, head presented combinationally
// from a register so outputs are glitch-free.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full unless a pop happens this edge)
//   push_data  : word to enqueue
//   pop        : remove head (ignored when empty)
//   head       : oldest word
//   not_empty  : at least one word stored
//   full       : QUEUE_DEPTH words stored
module word_fifo2
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             full
);

  logic [WIDTH-1:0] mem0_q;  // head slot
  logic [WIDTH-1:0] mem1_q;  // tail slot when two words are held
  logic [1:0]       cnt_q;
  logic             do_pop;
  logic             do_push;

  assign not_empty = (cnt_q != 2'd0);
  assign full      = (cnt_q == 2'(QUEUE_DEPTH));
  assign head      = mem0_q;

  // A pop frees a slot at the same edge, so a push into a full queue is accepted then.
  assign do_pop  = pop && not_empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            mem0_q <= push_data;
          end else begin
            mem0_q <= mem1_q;
            mem1_q <= push_data;
          end
        end
        2'b01: begin
          mem0_q <= mem1_q;
          mem1_q <= '0;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) begin
            mem0_q <= push_data;
          end else begin
            mem1_q <= push_data;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: deserialises the bit stream from the parallel-load shift register
// into WIDTH-bit words and queues them for a valid/ready consumer.
//   clk, rst    : clock, synchronous active-high reset
//   sin, sin_en : serial bit and its qualifying shift strobe
//   sync        : frame restart, drops any partial word
//   dout        : head-of-queue word; dout_valid marks it valid
//   dout_ready  : consumer accepts dout at this edge
//   overrun     : sticky, a completed word was dropped on a full queue
//   word_count  : delivered-word count, wraps
//   busy        : partial word in progress
module serial_word_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  localparam int unsigned        BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0]    LAST = BC_W'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             complete;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             overrun_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    complete = 1'b0;
    if (sin_en) begin
      if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], sin};
      else           shreg_d = {sin, shreg_q[WIDTH-1:1]};
    end
    // sync wins over completion; stale bits left in shreg are shifted out
    // before the restarted word can complete.
    if (sync) begin
      bitcnt_d = sin_en ? BC_W'(1) : '0;
    end else if (sin_en) begin
      if (bitcnt_q == LAST) begin
        bitcnt_d = '0;
        complete = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q + BC_W'(1);
      end
    end
    state_d = (bitcnt_d != '0) ? COLLECT : IDLE;
  end

  assign busy = (state_q == COLLECT);

  assign pop  = dout_valid && dout_ready;
  assign push = complete;

  word_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_d),
    .pop       (pop),
    .head      (dout),
    .not_empty (dout_valid),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (complete && fifo_full && !pop) overrun_q <= 1'b1;
      if (pop) count_q <= count_q + CNT_W'(1);
    end
  end

  assign overrun    = overrun_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       rst, sin, sin_en, sync, dout_ready;
  logic [3:0] dout, dout_l;
  logic       dout_valid, dout_valid_l;
  logic       overrun, overrun_l, busy, busy_l;
  logic [7:0] word_count;
  logic [1:0] word_count_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun), .word_count(word_count), .busy(busy)
  );

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(2)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .sync(sync),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .overrun(overrun_l), .word_count(word_count_l), .busy(busy_l)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sin = 1'b0; sin_en = 1'b0; sync = 1'b0; dout_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sin_en = 1'b1; sin = b;
    step();
    sin_en = 1'b0; sin = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (dout !== 4'h0) begin fails++; $display("FAIL rst_dout got %h want 0", dout); end
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", dout_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun got %b want 0", overrun); end
    tests++; if (word_count !== 8'd0) begin fails++; $display("FAIL rst_count got %0d want 0", word_count); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    do_reset();
    dout_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", dout_valid); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
    send_bit(1'b1);
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", dout_valid); end
    tests++; if (dout !== 4'h9) begin fails++; $display("FAIL basic_dout got %h want 9", dout); end
    tests++; if (dout_l !== 4'h9) begin fails++; $display("FAIL basic_dout_lsb got %h want 9", dout_l); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b want 0", busy); end
    step();
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got %b want 0", dout_valid); end
    tests++; if (word_count !== 8'd1) begin fails++; $display("FAIL basic_count got %0d want 1", word_count); end
    dout_ready = 1'b0;
  endtask

  task automatic test_bit_order();
    do_reset();
    dout_ready = 1'b1;
    send_word(4'b1100);
    tests++; if (dout !== 4'hC) begin fails++; $display("FAIL order_msb got %h want c", dout); end
    tests++; if (dout_l !== 4'h3) begin fails++; $display("FAIL order_lsb got %h want 3", dout_l); end
    step();
    dout_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    send_word(4'hA); send_word(4'h5); send_word(4'hF);
    tests++; if (dout !== 4'hA || dout_valid !== 1'b1) begin fails++; $display("FAIL bp_head got %h/%b want a/1", dout, dout_valid); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL bp_overrun got %b want 1", overrun); end
    step();
    tests++; if (dout !== 4'hA || dout_valid !== 1'b1) begin fails++; $display("FAIL bp_stable got %h/%b want a/1", dout, dout_valid); end
    dout_ready = 1'b1;
    step();
    tests++; if (dout !== 4'h5 || dout_valid !== 1'b1) begin fails++; $display("FAIL bp_second got %h/%b want 5/1", dout, dout_valid); end
    tests++; if (word_count !== 8'd1) begin fails++; $display("FAIL bp_count1 got %0d want 1", word_count); end
    step();
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %b want 0", dout_valid); end
    tests++; if (word_count !== 8'd2) begin fails++; $display("FAIL bp_count2 got %0d want 2", word_count); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL bp_sticky got %b want 1", overrun); end
    dout_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    send_word(4'hA); send_word(4'h5);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    dout_ready = 1'b1; sin_en = 1'b1; sin = 1'b1;
    step();
    sin_en = 1'b0; sin = 1'b0;
    tests++; if (dout !== 4'h5 || dout_valid !== 1'b1) begin fails++; $display("FAIL fp_head got %h/%b want 5/1", dout, dout_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL fp_overrun got %b want 0", overrun); end
    step();
    tests++; if (dout !== 4'hF || dout_valid !== 1'b1) begin fails++; $display("FAIL fp_tail got %h/%b want f/1", dout, dout_valid); end
    step();
    tests++; if (dout_valid !== 1'b0 || word_count !== 8'd3) begin fails++; $display("FAIL fp_end got %b/%0d want 0/3", dout_valid, word_count); end
    dout_ready = 1'b0;
  endtask

  task automatic test_gapped();
    logic [3:0] w;
    do_reset();
    dout_ready = 1'b1;
    w = 4'h6;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL gap_idle got %b want 0", busy); end
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i]);
      if (i != 0) begin
        for (int g = 0; g < 3; g++) begin
          tests++; if (busy !== 1'b1 || dout_valid !== 1'b0) begin fails++; $display("FAIL gap_busy got %b/%b want 1/0", busy, dout_valid); end
          step();
        end
      end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL gap_busy_end got %b want 0", busy); end
    tests++; if (dout !== 4'h6 || dout_valid !== 1'b1) begin fails++; $display("FAIL gap_dout got %h/%b want 6/1", dout, dout_valid); end
    step();
    dout_ready = 1'b0;
  endtask

  task automatic test_sync_mid();
    do_reset();
    dout_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1; sin_en = 1'b1; sin = 1'b0;
    step();
    sync = 1'b0; sin_en = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sync_busy got %b want 1", busy); end
    send_bit(1'b1);
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL sync_no_old got %b want 0", dout_valid); end
    send_bit(1'b1); send_bit(1'b0);
    tests++; if (dout !== 4'h6 || dout_valid !== 1'b1) begin fails++; $display("FAIL sync_dout got %h/%b want 6/1", dout, dout_valid); end
    step();
    tests++; if (word_count !== 8'd1 || dout_valid !== 1'b0) begin fails++; $display("FAIL sync_count got %0d/%b want 1/0", word_count, dout_valid); end
    dout_ready = 1'b0;
  endtask

  task automatic test_sync_priority();
    do_reset();
    dout_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sync = 1'b1; sin_en = 1'b1; sin = 1'b1;
    step();
    sync = 1'b0; sin_en = 1'b0;
    tests++; if (dout_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL prio_drop got %b/%b want 0/1", dout_valid, busy); end
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    tests++; if (dout !== 4'h9 || dout_valid !== 1'b1) begin fails++; $display("FAIL prio_dout got %h/%b want 9/1", dout, dout_valid); end
    step();
    dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(4'h3); send_word(4'hC); send_word(4'hF);
    send_bit(1'b1); send_bit(1'b1);
    tests++; if (overrun !== 1'b1 || dout_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL rm_pre got %b/%b/%b want 1/1/1", overrun, dout_valid, busy); end
    rst = 1'b1; sin_en = 1'b1; sin = 1'b1; dout_ready = 1'b1;
    step();
    rst = 1'b0; sin_en = 1'b0; sin = 1'b0;
    tests++; if (dout !== 4'h0 || dout_valid !== 1'b0 || overrun !== 1'b0 || word_count !== 8'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL rm_clear got %h/%b/%b/%0d/%b want 0/0/0/0/0", dout, dout_valid, overrun, word_count, busy);
    end
    send_word(4'h9);
    tests++; if (dout !== 4'h9 || dout_valid !== 1'b1) begin fails++; $display("FAIL rm_dout got %h/%b want 9/1", dout, dout_valid); end
    step();
    tests++; if (word_count !== 8'd1) begin fails++; $display("FAIL rm_count got %0d want 1", word_count); end
    dout_ready = 1'b0;
  endtask

  task automatic test_count_wrap();
    do_reset();
    dout_ready = 1'b1;
    for (int n = 0; n < 5; n++) send_word(4'h1);
    step();
    tests++; if (word_count !== 8'd5) begin fails++; $display("FAIL wrap_count8 got %0d want 5", word_count); end
    tests++; if (word_count_l !== 2'd1) begin fails++; $display("FAIL wrap_count2 got %0d want 1", word_count_l); end
    dout_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; sin_en = 1'b0; sync = 1'b0; dout_ready = 1'b0;
    step();
    test_reset();
    test_basic();
    test_bit_order();
    test_backpressure();
    test_full_pop();
    test_gapped();
    test_sync_mid();
    test_sync_priority();
    test_reset_mid();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
